// File: rtl/conv_tile_scheduler.sv
// Sequences Cout tiles (outer) x Cin tiles (inner) onto the fixed PE array, issuing one
// pe_controller start per tile and one psum drain per Cout tile.
module conv_tile_scheduler #(
    parameter int unsigned ARRAY_DIM = 16,
    parameter int unsigned CH_W      = 10,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_cin,
    input  logic [CH_W-1:0]   cfg_cout,
    input  logic [3:0]        cfg_kh,
    input  logic [3:0]        cfg_kw,
    input  logic [7:0]        cfg_in_h,
    input  logic [7:0]        cfg_in_w,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    input  logic              abort,
    output logic              tile_start,
    input  logic              tile_done,
    output logic [ADDR_W-1:0] tile_w_base,
    output logic [ADDR_W-1:0] tile_in_base,
    output logic              tile_first,
    output logic              tile_last,
    output logic              drain_start,
    input  logic              drain_done,
    output logic [ADDR_W-1:0] drain_out_base,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        StIdle, StCalc, StIssue, StWaitTile, StDrain, StWaitDrain, StFinish
    } state_e;

    state_e state_q, state_d;

    logic [CH_W-1:0]   cin_q, cout_q;
    logic [3:0]        kh_q, kw_q;
    logic [7:0]        in_h_q, in_w_q;
    logic [ADDR_W-1:0] w_base_q, in_base_q, out_base_q;

    logic [CH_W-1:0]   n_ci_q, n_co_q, ci_q, co_q;
    logic [ADDR_W-1:0] tw_q, plane_q;
    logic [ADDR_W-1:0] w_addr_q, in_addr_q, out_addr_q;
    logic              err_q;

    logic [CH_W:0]     cin_rnd, cout_rnd;
    logic [CH_W-1:0]   n_ci_calc, n_co_calc;
    logic [7:0]        kk;
    logic [15:0]       hw;
    logic [ADDR_W-1:0] tw_calc, plane_calc;
    logic              cfg_bad;
    logic              ci_is_last, co_is_last, in_tile;
    logic              accept, tile_adv, co_adv;

    // Ceiling division by the array edge, evaluated on the latched descriptor
    assign cin_rnd    = {1'b0, cin_q} + (CH_W+1)'(ARRAY_DIM - 1);
    assign cout_rnd   = {1'b0, cout_q} + (CH_W+1)'(ARRAY_DIM - 1);
    assign n_ci_calc  = CH_W'(cin_rnd / (CH_W+1)'(ARRAY_DIM));
    assign n_co_calc  = CH_W'(cout_rnd / (CH_W+1)'(ARRAY_DIM));
    assign kk         = {4'b0, kh_q} * {4'b0, kw_q};
    assign hw         = {8'b0, in_h_q} * {8'b0, in_w_q};
    assign tw_calc    = ADDR_W'(kk) * ADDR_W'(ARRAY_DIM * ARRAY_DIM);
    assign plane_calc = ADDR_W'(hw);
    assign cfg_bad    = (cin_q == '0) || (cout_q == '0) || (kh_q == '0) || (kw_q == '0) ||
                        ({4'b0, kh_q} > in_h_q) || ({4'b0, kw_q} > in_w_q);

    assign ci_is_last = (ci_q == n_ci_q - CH_W'(1));
    assign co_is_last = (co_q == n_co_q - CH_W'(1));
    assign in_tile    = (state_q == StIssue) || (state_q == StWaitTile);
    assign accept     = (state_q == StIdle) && cfg_valid;

    always_comb begin
        state_d  = state_q;
        tile_adv = 1'b0;
        co_adv   = 1'b0;
        case (state_q)
            StIdle:     if (cfg_valid) state_d = StCalc;
            StCalc:     state_d = cfg_bad ? StFinish : StIssue;
            StIssue:    state_d = StWaitTile;
            StWaitTile: begin
                if (tile_done) begin
                    if (ci_is_last) begin
                        state_d = StDrain;
                    end else begin
                        tile_adv = 1'b1;
                        state_d  = StIssue;
                    end
                end
            end
            StDrain:    state_d = StWaitDrain;
            StWaitDrain: begin
                if (drain_done) begin
                    if (co_is_last) begin
                        state_d = StFinish;
                    end else begin
                        co_adv  = 1'b1;
                        state_d = StIssue;
                    end
                end
            end
            StFinish:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        // Abort overrides any same-cycle completion and skips done/err
        if (abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            tile_adv = 1'b0;
            co_adv   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cin_q      <= '0;
            cout_q     <= '0;
            kh_q       <= '0;
            kw_q       <= '0;
            in_h_q     <= '0;
            in_w_q     <= '0;
            w_base_q   <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            n_ci_q     <= '0;
            n_co_q     <= '0;
            tw_q       <= '0;
            plane_q    <= '0;
            err_q      <= 1'b0;
            ci_q       <= '0;
            co_q       <= '0;
            w_addr_q   <= '0;
            in_addr_q  <= '0;
            out_addr_q <= '0;
        end else begin
            if (accept) begin
                cin_q      <= cfg_cin;
                cout_q     <= cfg_cout;
                kh_q       <= cfg_kh;
                kw_q       <= cfg_kw;
                in_h_q     <= cfg_in_h;
                in_w_q     <= cfg_in_w;
                w_base_q   <= cfg_w_base;
                in_base_q  <= cfg_in_base;
                out_base_q <= cfg_out_base;
            end
            if (state_q == StCalc) begin
                n_ci_q     <= n_ci_calc;
                n_co_q     <= n_co_calc;
                tw_q       <= tw_calc;
                plane_q    <= plane_calc;
                err_q      <= cfg_bad;
                ci_q       <= '0;
                co_q       <= '0;
                w_addr_q   <= w_base_q;
                in_addr_q  <= in_base_q;
                out_addr_q <= out_base_q;
            end
            // Weight tiles are contiguous across Cout boundaries, so w advances on both paths
            if (tile_adv) begin
                ci_q      <= ci_q + CH_W'(1);
                w_addr_q  <= w_addr_q + tw_q;
                in_addr_q <= in_addr_q + plane_q;
            end
            if (co_adv) begin
                co_q       <= co_q + CH_W'(1);
                ci_q       <= '0;
                w_addr_q   <= w_addr_q + tw_q;
                in_addr_q  <= in_base_q;
                out_addr_q <= out_addr_q + plane_q;
            end
        end
    end

    assign cfg_ready      = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign tile_start     = (state_q == StIssue);
    assign tile_w_base    = w_addr_q;
    assign tile_in_base   = in_addr_q;
    assign tile_first     = in_tile && (ci_q == '0);
    assign tile_last      = in_tile && ci_is_last;
    assign drain_start    = (state_q == StDrain);
    assign drain_out_base = out_addr_q;
    assign done           = (state_q == StFinish);
    assign err            = (state_q == StFinish) && err_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler: tiling order, address sequences, reject paths,
// abort, asynchronous reset and spurious handshakes.
module tb_conv_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [9:0]  cfg_cin = '0;
    logic [9:0]  cfg_cout = '0;
    logic [3:0]  cfg_kh = '0;
    logic [3:0]  cfg_kw = '0;
    logic [7:0]  cfg_in_h = '0;
    logic [7:0]  cfg_in_w = '0;
    logic [15:0] cfg_w_base = '0;
    logic [15:0] cfg_in_base = '0;
    logic [15:0] cfg_out_base = '0;
    logic        abort = 1'b0;
    logic        tile_start;
    logic        tile_done = 1'b0;
    logic [15:0] tile_w_base;
    logic [15:0] tile_in_base;
    logic        tile_first;
    logic        tile_last;
    logic        drain_start;
    logic        drain_done = 1'b0;
    logic [15:0] drain_out_base;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q_w[$];
    logic [15:0] q_in[$];
    logic [15:0] q_out[$];
    logic        q_first[$];
    logic        q_last[$];
    int          q_cyc[$];
    logic        job_done, job_err, timed_out, aborted;
    int          done_cyc, dd_cyc;

    conv_tile_scheduler #(
        .ARRAY_DIM(16),
        .CH_W(10),
        .ADDR_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_cin(cfg_cin),
        .cfg_cout(cfg_cout),
        .cfg_kh(cfg_kh),
        .cfg_kw(cfg_kw),
        .cfg_in_h(cfg_in_h),
        .cfg_in_w(cfg_in_w),
        .cfg_w_base(cfg_w_base),
        .cfg_in_base(cfg_in_base),
        .cfg_out_base(cfg_out_base),
        .abort(abort),
        .tile_start(tile_start),
        .tile_done(tile_done),
        .tile_w_base(tile_w_base),
        .tile_in_base(tile_in_base),
        .tile_first(tile_first),
        .tile_last(tile_last),
        .drain_start(drain_start),
        .drain_done(drain_done),
        .drain_out_base(drain_out_base),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input int cin, input int cout, input int kh, input int kw,
                            input int ih, input int iw, input int wb, input int ib,
                            input int ob);
        cfg_cin      = 10'(cin);
        cfg_cout     = 10'(cout);
        cfg_kh       = 4'(kh);
        cfg_kw       = 4'(kw);
        cfg_in_h     = 8'(ih);
        cfg_in_w     = 8'(iw);
        cfg_w_base   = 16'(wb);
        cfg_in_base  = 16'(ib);
        cfg_out_base = 16'(ob);
        cfg_valid    = 1'b1;
        tick();
        cfg_valid    = 1'b0;
    endtask

    // Acts as pe_controller and drain engine; records what the scheduler issued.
    task automatic run_job(input int max_cyc, input int abort_tile);
        int td;
        int dd;
        int ab;
        q_w.delete(); q_in.delete(); q_out.delete();
        q_first.delete(); q_last.delete(); q_cyc.delete();
        job_done = 0; job_err = 0; timed_out = 1; aborted = 0;
        done_cyc = -1; dd_cyc = -1;
        td = 0; dd = 0; ab = 0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            tick();
            tile_done  = 1'b0;
            drain_done = 1'b0;
            abort      = 1'b0;
            if (ab == 2) begin
                aborted = 1; timed_out = 0;
                break;
            end
            if (ab == 1) begin
                abort = 1'b1; td = 0; ab = 2;
            end
            if (tile_start) begin
                q_w.push_back(tile_w_base);
                q_in.push_back(tile_in_base);
                q_first.push_back(tile_first);
                q_last.push_back(tile_last);
                q_cyc.push_back(cyc);
                td = 3;
                if (q_w.size() == abort_tile) ab = 1;
            end else if (td > 0) begin
                td--;
                if (td == 0) tile_done = 1'b1;
            end
            if (drain_start) begin
                q_out.push_back(drain_out_base);
                dd = 2;
            end else if (dd > 0) begin
                dd--;
                if (dd == 0) begin
                    drain_done = 1'b1;
                    dd_cyc = cyc;
                end
            end
            if (done) begin
                job_done = 1; job_err = err; done_cyc = cyc; timed_out = 0;
                break;
            end
        end
        tile_done  = 1'b0;
        drain_done = 1'b0;
        abort      = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready);
        end
        n_checks++;
        if ({busy, tile_start, tile_first, tile_last, drain_start, done, err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {busy, tile_start, tile_first, tile_last, drain_start, done, err});
        end
        n_checks++;
        if ({tile_w_base, tile_in_base, drain_out_base} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_addrs: got %h %h %h want 0 0 0",
                     tile_w_base, tile_in_base, drain_out_base);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got ready=%b busy=%b want 1 0", cfg_ready, busy);
        end
    endtask

    task automatic test_single_tile;
        send_cfg(16, 16, 3, 3, 8, 8, 0, 16'h4000, 16'h8000);
        run_job(100, 0);
        n_checks++;
        if (q_w.size() !== 1) begin
            n_fail++; $display("FAIL t1_tile_count: got %0d want 1", q_w.size());
        end
        if (q_w.size() > 0) begin
            n_checks++;
            if ({q_w[0], q_in[0], q_first[0], q_last[0]} !== {16'h0000, 16'h4000, 2'b11}) begin
                n_fail++;
                $display("FAIL t1_tile: got w=%h in=%h first=%b last=%b want 0000 4000 1 1",
                         q_w[0], q_in[0], q_first[0], q_last[0]);
            end
        end
        n_checks++;
        if (q_out.size() !== 1) begin
            n_fail++; $display("FAIL t1_drain_count: got %0d want 1", q_out.size());
        end else begin
            n_checks++;
            if (q_out[0] !== 16'h8000) begin
                n_fail++; $display("FAIL t1_drain_out: got %h want 8000", q_out[0]);
            end
        end
        n_checks++;
        if (job_done !== 1'b1 || job_err !== 1'b0) begin
            n_fail++; $display("FAIL t1_done: got done=%b err=%b want 1 0", job_done, job_err);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL t1_idle: got busy=%b ready=%b want 0 1", busy, cfg_ready);
        end
    endtask

    task automatic test_multi_tile;
        logic [15:0] exp_w[6];
        logic [15:0] exp_in[6];
        exp_w  = '{16'd0, 16'd2304, 16'd4608, 16'd6912, 16'd9216, 16'd11520};
        exp_in = '{16'd0, 16'd64, 16'd128, 16'd0, 16'd64, 16'd128};
        send_cfg(40, 20, 3, 3, 8, 8, 0, 0, 0);
        run_job(300, 0);
        n_checks++;
        if (q_w.size() !== 6) begin
            n_fail++; $display("FAIL t2_tile_count: got %0d want 6", q_w.size());
        end
        for (int i = 0; i < 6 && i < q_w.size(); i++) begin
            n_checks++;
            if (q_w[i] !== exp_w[i] || q_in[i] !== exp_in[i]) begin
                n_fail++;
                $display("FAIL t2_tile%0d_addr: got w=%0d in=%0d want %0d %0d",
                         i, q_w[i], q_in[i], exp_w[i], exp_in[i]);
            end
            n_checks++;
            if (q_first[i] !== (i % 3 == 0) || q_last[i] !== (i % 3 == 2)) begin
                n_fail++;
                $display("FAIL t2_tile%0d_flags: got first=%b last=%b want %b %b",
                         i, q_first[i], q_last[i], (i % 3 == 0), (i % 3 == 2));
            end
        end
        n_checks++;
        if (q_out.size() !== 2) begin
            n_fail++; $display("FAIL t2_drain_count: got %0d want 2", q_out.size());
        end else begin
            n_checks++;
            if (q_out[0] !== 16'd0 || q_out[1] !== 16'd64) begin
                n_fail++; $display("FAIL t2_drain_out: got %0d %0d want 0 64", q_out[0], q_out[1]);
            end
        end
        if (q_cyc.size() > 1) begin
            n_checks++;
            if (q_cyc[1] - q_cyc[0] !== 4) begin
                n_fail++;
                $display("FAIL t2_tile_latency: got %0d want 4 cycles", q_cyc[1] - q_cyc[0]);
            end
        end
        n_checks++;
        if (job_done !== 1'b1 || job_err !== 1'b0 || done_cyc - dd_cyc !== 1) begin
            n_fail++;
            $display("FAIL t2_done: got done=%b err=%b lat=%0d want 1 0 1",
                     job_done, job_err, done_cyc - dd_cyc);
        end
        tick();
    endtask

    task automatic test_bad_cfg;
        send_cfg(0, 16, 3, 3, 8, 8, 0, 0, 0);
        run_job(20, 0);
        n_checks++;
        if (job_done !== 1'b1 || job_err !== 1'b1 || done_cyc !== 1) begin
            n_fail++;
            $display("FAIL t3_cin0_done: got done=%b err=%b cyc=%0d want 1 1 1",
                     job_done, job_err, done_cyc);
        end
        n_checks++;
        if (q_w.size() !== 0 || q_out.size() !== 0) begin
            n_fail++;
            $display("FAIL t3_cin0_issue: got tiles=%0d drains=%0d want 0 0",
                     q_w.size(), q_out.size());
        end
        tick();
        send_cfg(16, 16, 5, 3, 4, 8, 0, 0, 0);
        run_job(20, 0);
        n_checks++;
        if (job_done !== 1'b1 || job_err !== 1'b1 || done_cyc !== 1 || q_w.size() !== 0) begin
            n_fail++;
            $display("FAIL t3_kh_gt_h: got done=%b err=%b cyc=%0d tiles=%0d want 1 1 1 0",
                     job_done, job_err, done_cyc, q_w.size());
        end
        tick();
    endtask

    task automatic test_abort;
        int seen;
        send_cfg(40, 20, 3, 3, 8, 8, 0, 0, 0);
        run_job(300, 2);
        n_checks++;
        if (aborted !== 1'b1 || q_w.size() !== 2) begin
            n_fail++;
            $display("FAIL t4_abort_point: got aborted=%b tiles=%0d want 1 2", aborted, q_w.size());
        end
        n_checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL t4_abort_idle: got busy=%b ready=%b want 0 1", busy, cfg_ready);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || err || tile_start || drain_start) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL t4_no_pulses: got %0d pulse cycles want 0", seen);
        end
        send_cfg(16, 16, 3, 3, 8, 8, 0, 16'h4000, 16'h8000);
        run_job(100, 0);
        n_checks++;
        if (q_w.size() !== 1 || job_done !== 1'b1 || job_err !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_new_job: got tiles=%0d done=%b err=%b want 1 1 0",
                     q_w.size(), job_done, job_err);
        end else begin
            n_checks++;
            if (q_in[0] !== 16'h4000 || q_out.size() !== 1) begin
                n_fail++; $display("FAIL t4_new_job_addr: got in=%h drains=%0d want 4000 1",
                                   q_in[0], q_out.size());
            end
        end
        tick();
    endtask

    task automatic test_rst_mid_drain;
        send_cfg(16, 16, 3, 3, 8, 8, 0, 16'h4000, 16'h8000);
        tick();
        tick();
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
        n_checks++;
        if (drain_start !== 1'b1) begin
            n_fail++; $display("FAIL t5_drain_start: got %b want 1", drain_start);
        end
        tick();
        n_checks++;
        if (busy !== 1'b1 || drain_out_base !== 16'h8000) begin
            n_fail++; $display("FAIL t5_wait_drain: got busy=%b out=%h want 1 8000",
                               busy, drain_out_base);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || drain_out_base !== 16'h0 ||
            tile_in_base !== 16'h0) begin
            n_fail++;
            $display("FAIL t5_async_rst: got busy=%b ready=%b out=%h in=%h want 0 1 0000 0000",
                     busy, cfg_ready, drain_out_base, tile_in_base);
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL t5_release: got ready=%b busy=%b done=%b want 1 0 0",
                               cfg_ready, busy, done);
        end
    endtask

    task automatic test_spurious;
        tile_done = 1'b1; drain_done = 1'b1; abort = 1'b1;
        tick();
        tile_done = 1'b0; drain_done = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || {tile_start, drain_start, done} !== 3'b0) begin
            n_fail++; $display("FAIL t6_idle_spurious: got busy=%b ready=%b pulses=%b want 0 1 000",
                               busy, cfg_ready, {tile_start, drain_start, done});
        end
        send_cfg(16, 16, 3, 3, 8, 8, 0, 16'h4000, 16'h8000);
        tick();
        n_checks++;
        if (tile_start !== 1'b1 || tile_in_base !== 16'h4000) begin
            n_fail++; $display("FAIL t6_issue: got start=%b in=%h want 1 4000",
                               tile_start, tile_in_base);
        end
        cfg_valid = 1'b1; cfg_cin = 10'd40; cfg_in_base = 16'h1111; cfg_out_base = 16'h2222;
        tick();
        n_checks++;
        if (cfg_ready !== 1'b0 || tile_start !== 1'b0 || tile_in_base !== 16'h4000 ||
            tile_first !== 1'b1 || tile_last !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_busy_hold: got ready=%b start=%b in=%h f=%b l=%b want 0 0 4000 1 1",
                     cfg_ready, tile_start, tile_in_base, tile_first, tile_last);
        end
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
        n_checks++;
        if (drain_start !== 1'b1 || drain_out_base !== 16'h8000) begin
            n_fail++; $display("FAIL t6_drain: got start=%b out=%h want 1 8000",
                               drain_start, drain_out_base);
        end
        cfg_valid = 1'b0;
        tick();
        drain_done = 1'b1;
        tick();
        drain_done = 1'b0;
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL t6_done: got done=%b err=%b want 1 0", done, err);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL t6_final_idle: got busy=%b ready=%b want 0 1", busy, cfg_ready);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_tile();
        test_multi_tile();
        test_bad_cfg();
        test_abort();
        test_rst_mid_drain();
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
